axis_phase_decoder: RTL and testbench
=====================================

Name: axis_phase_decoder

Overview:
- AXI-Stream slave that consumes a phase-accumulator stream and recovers the per-sample phase increment.
- Per sample it forms the modular difference between consecutive phase words, sums N differences, then emits the signed sum on an AXI-Stream master.
- Sits downstream of the phase generator; a loopback bench checks that the recovered increment equals the programmed increment times N.

Parameters:
- S_AXIS_TDATA_WIDTH, 32, input stream width; only the low PHASE_WIDTH bits are used.
- PHASE_WIDTH, 30, phase word width.
- CNTR_WIDTH, 16, width of window-length config and window counter.
- M_AXIS_TDATA_WIDTH, 64, output width; must be >= PHASE_WIDTH+CNTR_WIDTH.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset.
- cfg_data  in  CNTR_WIDTH  window length N (differences per output).
- s_axis_tready  out  1  input ready.
- s_axis_tdata  in  S_AXIS_TDATA_WIDTH  phase sample.
- s_axis_tvalid  in  1  input valid.
- m_axis_tready  in  1  output ready.
- m_axis_tdata  out  M_AXIS_TDATA_WIDTH  sign-extended sum of N differences.
- m_axis_tvalid  out  1  output valid.

Behaviour:
- Reset: aresetn, synchronous, active-low; clock aclk.
- Values after reset:
  - state=PRIME; prev, acc and cntr = 0.
  - m_axis_tvalid=0, m_axis_tdata=0.
  - s_axis_tready=1 from the first cycle after reset release; it is 0 while aresetn is low.
- Transfers:
  - An input transfer occurs when s_axis_tvalid & s_axis_tready.
  - An output transfer occurs when m_axis_tvalid & m_axis_tready.
- s_axis_tready = (state != HOLD). It is combinational from registered state only, with no path from m_axis_tready.
- Difference d = (cur - prev) mod 2^PHASE_WIDTH, interpreted as two's-complement signed. Wrap-around therefore yields a small difference, e.g. prev=0x3FFFFFF0, cur=0x10 gives d=+0x20.
- d is sign-extended to PHASE_WIDTH+CNTR_WIDTH. acc has that width and never overflows for N <= 2^CNTR_WIDTH-1.
- Window length: N_eff = max(cfg_data, 1). It is latched into n_lat when a window starts, i.e. on the PRIME exit and on each HOLD exit. Changes to cfg_data mid-window have no effect on the current window.
- State PRIME:
  - On an input transfer: prev<=cur, acc<=0, cntr<=0, latch n_lat, go to ACCUM.
  - No output is produced.
- State ACCUM, on an input transfer:
  - prev<=cur, acc<=acc+d, cntr<=cntr+1.
  - If cntr+1 == n_lat: load out register with sext(acc+d), m_axis_tvalid<=1, go to HOLD.
- State HOLD:
  - m_axis_tvalid=1; tdata stays stable until the output transfer.
  - On the output transfer: m_axis_tvalid<=0, acc<=0, cntr<=0, latch n_lat, go to ACCUM.
  - prev is retained, so the next difference is contiguous with the last sample; no sample is dropped.
- Latency: m_axis_tvalid rises 1 cycle after the Nth difference transfer.
- Throughput: one bubble cycle per window (HOLD minimum 1 cycle).
- Reset mid-window or mid-HOLD: everything is discarded and the block returns to PRIME; a pending output is lost and no partial output is emitted.
- Gaps in s_axis_tvalid are tolerated; only transfers count.

Optional Feature:
- Macro AXIS_PHASE_DECODER_JUMP_EN.
- When defined:
  - Adds output port m_axis_tuser, 1 bit, reset 0.
  - The first difference of each window is stored as d0.
  - m_axis_tuser is set with the output if any later difference in the window differs from d0, i.e. the increment changed within the window. It is valid with m_axis_tvalid.
- When undefined: no port, no d0 register, identical behaviour otherwise.

Decomposition:
- Shared package phase_pkg:
  - State encoding constants PRIME=2'd0, ACCUM=2'd1, HOLD=2'd2.
  - Localparam for accumulator width PHASE_WIDTH+CNTR_WIDTH.
- One sub-module, phase_diff_unit: combinational modular subtract plus sign extension (cur, prev -> d). It is reused by future phase-domain blocks.

Test Plan:
- Constant increment, default widths:
  - Stimulus: cfg_data=4; samples 0,100,200,…,800 with continuous valid and m_axis_tready=1.
  - Response: outputs 400 after sample 4 and 400 after sample 8. The sample arriving during HOLD is stalled, not lost.
- Wrap-around:
  - Stimulus: cfg_data=1; samples 0x3FFFFFF0 then 0x00000010.
  - Response: output 0x20. Then samples 0x10, 0x3FFFFFF0 give output sign-extended -0x20 (0xFFFF…FFE0).
- cfg_data=0:
  - Response: behaves as N=1, one output per input after the first.
  - Changing cfg_data from 4 to 2 mid-window does not alter that window's output count.
- Backpressure:
  - Stimulus: m_axis_tready=0 for 10 cycles after the output asserts.
  - Response: tdata stays stable, s_axis_tready=0 throughout, and the next window sum is still correct (contiguous prev).
- Reset mid-HOLD:
  - Stimulus: aresetn low 1 cycle while m_axis_tvalid=1.
  - Response: m_axis_tvalid=0 next cycle; the first sample after reset only primes, with no output.
- JUMP_EN build:
  - Stimulus: N=4; differences 10,10,11,10.
  - Response: output 41 with m_axis_tuser=1. Differences 10,10,10,10 give 40 with tuser=0.

Source files
------------

// File: rtl/phase_pkg.sv
// Shared phase-domain definitions: FSM state encoding and default datapath widths.
package phase_pkg;

  localparam int unsigned PHASE_WIDTH_DEF = 30;
  localparam int unsigned CNTR_WIDTH_DEF  = 16;
  localparam int unsigned ACC_WIDTH       = PHASE_WIDTH_DEF + CNTR_WIDTH_DEF;

  typedef enum logic [1:0] {
    PRIME = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/phase_diff_unit.sv
// Modular phase difference (cur - prev) mod 2^PHASE_WIDTH, sign-extended to OUT_WIDTH.
module phase_diff_unit #(
  parameter int unsigned PHASE_WIDTH = 30,
  parameter int unsigned OUT_WIDTH   = 46
) (
  input  logic [PHASE_WIDTH-1:0] cur,
  input  logic [PHASE_WIDTH-1:0] prev,
  output logic [OUT_WIDTH-1:0]   d_c
);

  logic [PHASE_WIDTH-1:0] raw;

  // Truncating subtract gives the wrap-safe shortest-path difference
  assign raw = cur - prev;
  assign d_c = OUT_WIDTH'($signed(raw));

endmodule

// File: rtl/axis_phase_decoder.sv
// Recovers the per-window phase increment sum from an AXI-Stream phase-accumulator feed.
// Optional AXIS_PHASE_DECODER_JUMP_EN adds m_axis_tuser flagging an increment change within a window.
module axis_phase_decoder
  import phase_pkg::*;
#(
  parameter int unsigned S_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned PHASE_WIDTH        = 30,
  parameter int unsigned CNTR_WIDTH         = 16,
  parameter int unsigned M_AXIS_TDATA_WIDTH = 64
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [CNTR_WIDTH-1:0]         cfg_data,
  output logic                          s_axis_tready,
  input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid
`ifdef AXIS_PHASE_DECODER_JUMP_EN
  ,
  output logic                          m_axis_tuser
`endif
);

  localparam int unsigned ACC_W = PHASE_WIDTH + CNTR_WIDTH;

  state_t                        state_q, state_d;
  logic [PHASE_WIDTH-1:0]        prev_q, prev_d;
  logic [ACC_W-1:0]              acc_q, acc_d;
  logic [CNTR_WIDTH-1:0]         cntr_q, cntr_d;
  logic [CNTR_WIDTH-1:0]         n_lat_q, n_lat_d;
  logic [M_AXIS_TDATA_WIDTH-1:0] out_q, out_d;
  logic                          valid_q, valid_d;
  logic                          ready_q, ready_d;

  logic [PHASE_WIDTH-1:0]        cur;
  logic [ACC_W-1:0]              d;
  logic [ACC_W-1:0]              acc_sum;
  logic [CNTR_WIDTH-1:0]         cntr_inc;
  logic [CNTR_WIDTH-1:0]         n_cfg;
  logic                          in_xfer;
  logic                          out_xfer;

`ifdef AXIS_PHASE_DECODER_JUMP_EN
  logic [ACC_W-1:0]              d0_q, d0_d;
  logic                          jump_q, jump_d;
  logic                          tuser_q, tuser_d;
  logic                          jump_hit;
`endif

  assign cur = s_axis_tdata[PHASE_WIDTH-1:0];

  generate
    if (S_AXIS_TDATA_WIDTH > PHASE_WIDTH) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^s_axis_tdata[S_AXIS_TDATA_WIDTH-1:PHASE_WIDTH];
    end
  endgenerate

  phase_diff_unit #(
    .PHASE_WIDTH (PHASE_WIDTH),
    .OUT_WIDTH   (ACC_W)
  ) u_diff (
    .cur  (cur),
    .prev (prev_q),
    .d_c  (d)
  );

  assign in_xfer  = s_axis_tvalid & ready_q;
  assign out_xfer = valid_q & m_axis_tready;
  assign acc_sum  = acc_q + d;
  assign cntr_inc = cntr_q + CNTR_WIDTH'(1);
  assign n_cfg    = (cfg_data == '0) ? CNTR_WIDTH'(1) : cfg_data;

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    acc_d   = acc_q;
    cntr_d  = cntr_q;
    n_lat_d = n_lat_q;
    out_d   = out_q;
    valid_d = valid_q;
`ifdef AXIS_PHASE_DECODER_JUMP_EN
    d0_d     = d0_q;
    jump_d   = jump_q;
    tuser_d  = tuser_q;
    jump_hit = (cntr_q != '0) && (d != d0_q);
`endif
    unique case (state_q)
      PRIME: begin
        if (in_xfer) begin
          prev_d  = cur;
          acc_d   = '0;
          cntr_d  = '0;
          n_lat_d = n_cfg;
`ifdef AXIS_PHASE_DECODER_JUMP_EN
          jump_d  = 1'b0;
`endif
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_xfer) begin
          prev_d = cur;
          acc_d  = acc_sum;
          cntr_d = cntr_inc;
`ifdef AXIS_PHASE_DECODER_JUMP_EN
          if (cntr_q == '0) d0_d = d;
          jump_d = jump_q | jump_hit;
`endif
          if (cntr_inc == n_lat_q) begin
            out_d   = M_AXIS_TDATA_WIDTH'($signed(acc_sum));
            valid_d = 1'b1;
`ifdef AXIS_PHASE_DECODER_JUMP_EN
            tuser_d = jump_q | jump_hit;
`endif
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // prev is kept so the next window continues from the last sample
        if (out_xfer) begin
          valid_d = 1'b0;
          acc_d   = '0;
          cntr_d  = '0;
          n_lat_d = n_cfg;
`ifdef AXIS_PHASE_DECODER_JUMP_EN
          jump_d  = 1'b0;
`endif
          state_d = ACCUM;
        end
      end
      default: state_d = PRIME;
    endcase
    ready_d = (state_d != HOLD);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= PRIME;
      prev_q  <= '0;
      acc_q   <= '0;
      cntr_q  <= '0;
      n_lat_q <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
`ifdef AXIS_PHASE_DECODER_JUMP_EN
      d0_q    <= '0;
      jump_q  <= 1'b0;
      tuser_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      acc_q   <= acc_d;
      cntr_q  <= cntr_d;
      n_lat_q <= n_lat_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
`ifdef AXIS_PHASE_DECODER_JUMP_EN
      d0_q    <= d0_d;
      jump_q  <= jump_d;
      tuser_q <= tuser_d;
`endif
    end
  end

  assign s_axis_tready = ready_q;
  assign m_axis_tdata  = out_q;
  assign m_axis_tvalid = valid_q;
`ifdef AXIS_PHASE_DECODER_JUMP_EN
  assign m_axis_tuser  = tuser_q;
`endif

endmodule

// File: tb/tb_axis_phase_decoder.sv
// Self-checking bench for axis_phase_decoder: directed vector table, corner sequences, random vs model.
module tb_axis_phase_decoder;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [15:0] cfg_data;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        m_axis_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
`ifdef AXIS_PHASE_DECODER_JUMP_EN
  logic        m_axis_tuser;
`endif

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axis_phase_decoder dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_data      (cfg_data),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid)
`ifdef AXIS_PHASE_DECODER_JUMP_EN
    ,
    .m_axis_tuser  (m_axis_tuser)
`endif
  );

  typedef struct {
    bit          rst;
    logic [15:0] cfg;
    logic [31:0] sample;
    bit          exp_v;
    logic [63:0] exp_d;
  } vec_t;

  // Observed transfers for the random phase
  bit          mon_en = 1'b0;
  logic [29:0] in_seen[$];
  logic [63:0] out_seen[$];

  always @(negedge aclk) begin
    if (mon_en && aresetn) begin
      if (s_axis_tvalid && s_axis_tready) in_seen.push_back(s_axis_tdata[29:0]);
      if (m_axis_tvalid && m_axis_tready) out_seen.push_back(m_axis_tdata);
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;
    tick();
    tick();
    aresetn = 1'b1;
    tick();
  endtask

  // Present one sample and hold it until accepted (bounded)
  task automatic send(input logic [31:0] v);
    int n;
    n = 0;
    s_axis_tdata  = v;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 50) begin
      tick();
      n++;
    end
    if (!s_axis_tready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got tready=0 expected tready=1 within 50 cycles");
    end
    tick();
    s_axis_tvalid = 1'b0;
  endtask

  // Signed modular difference of two 30-bit phase words
  function automatic longint sdiff(input logic [29:0] cur, input logic [29:0] prv);
    longint x;
    x = (longint'(cur) - longint'(prv)) & 64'h3FFF_FFFF;
    if (x >= 64'sh2000_0000) x = x - 64'sh4000_0000;
    return x;
  endfunction

  vec_t vecs[$];

  initial begin
    longint sum;
    int     nwin;
    int     nn;

    aresetn       = 1'b0;
    cfg_data      = 16'd4;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;

    // Reset values
    tick();
    tick();
    check("rst_tready", 64'(s_axis_tready), 64'd0);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    aresetn = 1'b1;
    tick();
    check("post_rst_tready", 64'(s_axis_tready), 64'd1);

    // Constant increment, N=4
    for (int i = 0; i <= 8; i++)
      vecs.push_back('{(i == 0), 16'd4, 32'(i * 100), (i == 4 || i == 8), 64'd400});
    // Wrap-around, N=1
    vecs.push_back('{1'b1, 16'd1, 32'h3FFF_FFF0, 1'b0, 64'd0});
    vecs.push_back('{1'b0, 16'd1, 32'h0000_0010, 1'b1, 64'h20});
    vecs.push_back('{1'b0, 16'd1, 32'h0000_0010, 1'b1, 64'h0});
    vecs.push_back('{1'b0, 16'd1, 32'h3FFF_FFF0, 1'b1, 64'hFFFF_FFFF_FFFF_FFE0});
    // cfg_data=0 acts as N=1; upper tdata bits ignored
    vecs.push_back('{1'b1, 16'd0, 32'hC000_0005, 1'b0, 64'd0});
    vecs.push_back('{1'b0, 16'd0, 32'h0000_000C, 1'b1, 64'd7});
    vecs.push_back('{1'b0, 16'd0, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFF3});
    // cfg change 4->2 mid-window does not shorten the current window
    vecs.push_back('{1'b1, 16'd4, 32'd0, 1'b0, 64'd0});
    vecs.push_back('{1'b0, 16'd4, 32'd3, 1'b0, 64'd0});
    vecs.push_back('{1'b0, 16'd2, 32'd6, 1'b0, 64'd0});
    vecs.push_back('{1'b0, 16'd2, 32'd9, 1'b0, 64'd0});
    vecs.push_back('{1'b0, 16'd2, 32'd12, 1'b1, 64'd12});
    vecs.push_back('{1'b0, 16'd2, 32'd14, 1'b0, 64'd0});
    vecs.push_back('{1'b0, 16'd2, 32'd16, 1'b1, 64'd4});

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      cfg_data = vecs[i].cfg;
      send(vecs[i].sample);
      check($sformatf("vec%0d_tvalid", i), 64'(m_axis_tvalid), 64'(vecs[i].exp_v));
      if (vecs[i].exp_v) check($sformatf("vec%0d_tdata", i), m_axis_tdata, vecs[i].exp_d);
    end

    // Backpressure: output held 10 cycles, input stalled, next window contiguous
    do_reset();
    cfg_data      = 16'd2;
    m_axis_tready = 1'b0;
    send(32'd0);
    send(32'd50);
    send(32'd100);
    for (int i = 0; i < 10; i++) begin
      check("bp_tvalid", 64'(m_axis_tvalid), 64'd1);
      check("bp_tdata", m_axis_tdata, 64'd100);
      check("bp_tready", 64'(s_axis_tready), 64'd0);
      tick();
    end
    m_axis_tready = 1'b1;
    tick();
    check("bp_release_tvalid", 64'(m_axis_tvalid), 64'd0);
    send(32'd150);
    check("bp_mid_tvalid", 64'(m_axis_tvalid), 64'd0);
    send(32'd200);
    check("bp_next_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("bp_next_tdata", m_axis_tdata, 64'd100);

    // Reset while holding an output
    do_reset();
    cfg_data      = 16'd1;
    m_axis_tready = 1'b0;
    send(32'd0);
    send(32'd7);
    check("hold_tvalid", 64'(m_axis_tvalid), 64'd1);
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    check("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    m_axis_tready = 1'b1;
    send(32'd20);
    check("midrst_prime_tvalid", 64'(m_axis_tvalid), 64'd0);
    send(32'd25);
    check("midrst_out_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("midrst_out_tdata", m_axis_tdata, 64'd5);

`ifdef AXIS_PHASE_DECODER_JUMP_EN
    // Increment change inside a window raises tuser
    do_reset();
    cfg_data = 16'd4;
    send(32'd1000);
    send(32'd1010);
    send(32'd1020);
    send(32'd1031);
    send(32'd1041);
    check("jump_tdata", m_axis_tdata, 64'd41);
    check("jump_tuser", 64'(m_axis_tuser), 64'd1);
    send(32'd1051);
    send(32'd1061);
    send(32'd1071);
    send(32'd1081);
    check("flat_tdata", m_axis_tdata, 64'd40);
    check("flat_tuser", 64'(m_axis_tuser), 64'd0);
`endif

    // Random traffic against a window-sum model
    for (int r = 0; r < 2; r++) begin
      do_reset();
      nn       = (r == 0) ? 3 : int'($urandom_range(1, 7));
      cfg_data = 16'(nn);
      in_seen.delete();
      out_seen.delete();
      mon_en = 1'b1;
      for (int c = 0; c < 3000; c++) begin
        s_axis_tvalid = ($urandom_range(0, 3) != 0);
        s_axis_tdata  = $urandom;
        m_axis_tready = ($urandom_range(0, 3) != 0);
        tick();
      end
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;
      for (int c = 0; c < 5; c++) tick();
      mon_en = 1'b0;
      nwin = (in_seen.size() > 0) ? (in_seen.size() - 1) / nn : 0;
      check($sformatf("rnd%0d_count", r), 64'(out_seen.size()), 64'(nwin));
      for (int k = 0; k < nwin && k < out_seen.size(); k++) begin
        sum = 0;
        for (int i = k * nn + 1; i <= (k + 1) * nn; i++) sum += sdiff(in_seen[i], in_seen[i-1]);
        check($sformatf("rnd%0d_win%0d", r, k), out_seen[k], 64'(sum));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
